// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_BD_MIN    = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_init,
    input  logic i_rxd,
    output logic o_rxd_s
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else if (i_init) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_rxd;
            r_sync <= r_meta;
        end
    end

    assign o_rxd_s = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: synchronised line, mid-bit sampling FSM, one-entry output holding register.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point, one cycle later per decision.
//
//  state  | meaning
//  IDLE   | waiting for a falling edge (only once the line has been seen high)
//  START  | half a bit into the start bit, confirm it is still low
//  DATA   | 8 data samples, LSB first
//  PARITY | parity sample, compared against received data
//  STOP1  | first stop sample, 0 marks a framing error
//  STOP2  | second stop sample when two stop bits are configured
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BDWIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ctrl_init,
    input  logic [BDWIDTH-1:0] ctrl_baud_divisor,
    input  logic               ctrl_stop_bits,
    input  logic               ctrl_parity_ena,
    input  logic               ctrl_parity_type,
    input  logic               uart_rxd,
    output logic [7:0]         rx_data,
    output logic               rx_perr,
    output logic               rx_ferr,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               rx_overrun
);

    uart_rx_state_t r_state;
    uart_rx_state_t w_state_nxt;

    logic               w_rxd_s;
    logic               w_tick;
    logic               w_decide;
    logic               w_bit;
    logic               w_start;
    logic               w_done;
    logic [BDWIDTH-1:0] w_div_eff;
    logic [BDWIDTH-1:0] w_target;

    logic [BDWIDTH-1:0] r_div;
    logic               r_stop2;
    logic               r_par_ena;
    logic               r_par_type;
    logic [BDWIDTH-1:0] r_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_perr_acc;
    logic               r_ferr_acc;
    logic               r_armed;
    logic               r_done;

    logic [7:0]         r_rx_data;
    logic               r_rx_perr;
    logic               r_rx_ferr;
    logic               r_rx_valid;
    logic               r_rx_overrun;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_init  (ctrl_init),
        .i_rxd   (uart_rxd),
        .o_rxd_s (w_rxd_s)
    );

    assign w_div_eff = (ctrl_baud_divisor < BDWIDTH'(UART_BD_MIN)) ? BDWIDTH'(UART_BD_MIN)
                                                                   : ctrl_baud_divisor;
    // Start bit is checked half a bit in; every later sample is one full bit apart.
    assign w_target  = (r_state == START) ? ((r_div >> 1) - BDWIDTH'(1)) : (r_div - BDWIDTH'(1));
    assign w_tick    = (r_state != IDLE) && (r_cnt == w_target);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;
    logic       r_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist <= 2'b11;
            r_pend <= 1'b0;
        end else if (ctrl_init) begin
            r_hist <= 2'b11;
            r_pend <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], w_rxd_s};
            r_pend <= w_tick;
        end
    end

    // Decision waits one cycle so the sample after the sample point is available.
    assign w_decide = r_pend;
    assign w_bit    = maj3(r_hist[1], r_hist[0], w_rxd_s);
`else
    assign w_decide = w_tick;
    assign w_bit    = w_rxd_s;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else if (ctrl_init) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_armed && !w_rxd_s) begin
                    w_state_nxt = START;
                    w_start     = 1'b1;
                end
            end
            START: begin
                if (w_decide) begin
                    w_state_nxt = w_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_decide && (r_bit_cnt == 3'(UART_DATA_BITS - 1))) begin
                    w_state_nxt = r_par_ena ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (w_decide) begin
                    w_state_nxt = STOP1;
                end
            end
            STOP1: begin
                if (w_decide) begin
                    if (r_stop2) begin
                        w_state_nxt = STOP2;
                    end else begin
                        w_state_nxt = IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (w_decide) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div      <= BDWIDTH'(UART_BD_MIN);
            r_stop2    <= 1'b0;
            r_par_ena  <= 1'b0;
            r_par_type <= 1'b0;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_armed    <= 1'b0;
            r_done     <= 1'b0;
        end else if (ctrl_init) begin
            r_div      <= BDWIDTH'(UART_BD_MIN);
            r_stop2    <= 1'b0;
            r_par_ena  <= 1'b0;
            r_par_type <= 1'b0;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_armed    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_done;

            if (r_state == IDLE || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + BDWIDTH'(1);
            end

            // Frame configuration is frozen at the start edge.
            if (w_start) begin
                r_div      <= w_div_eff;
                r_stop2    <= ctrl_stop_bits;
                r_par_ena  <= ctrl_parity_ena;
                r_par_type <= ctrl_parity_type;
                r_bit_cnt  <= '0;
                r_perr_acc <= 1'b0;
                r_ferr_acc <= 1'b0;
            end

            if (w_decide && r_state == DATA) begin
                r_shift   <= {w_bit, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_decide && r_state == PARITY) begin
                r_perr_acc <= (^r_shift) ^ w_bit ^ r_par_type;
            end

            if (w_decide && (r_state == STOP1 || r_state == STOP2)) begin
                r_ferr_acc <= r_ferr_acc | ~w_bit;
            end

            // A low final stop sample leaves the receiver disarmed until the line idles high.
            if (w_done) begin
                r_armed <= w_bit;
            end else if (r_state == START && w_decide && w_bit) begin
                r_armed <= 1'b1;
            end else if (r_state == IDLE && w_rxd_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_data    <= '0;
            r_rx_perr    <= 1'b0;
            r_rx_ferr    <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else if (ctrl_init) begin
            r_rx_data    <= '0;
            r_rx_perr    <= 1'b0;
            r_rx_ferr    <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_overrun <= 1'b0;
            if (r_done) begin
                if (r_rx_valid && !rx_ready) begin
                    r_rx_overrun <= 1'b1;
                end else begin
                    r_rx_data  <= r_shift;
                    r_rx_perr  <= r_perr_acc;
                    r_rx_ferr  <= r_ferr_acc;
                    r_rx_valid <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_perr    = r_rx_perr;
    assign rx_ferr    = r_rx_ferr;
    assign rx_valid   = r_rx_valid;
    assign rx_overrun = r_rx_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are driven bit by bit, deliveries logged at the falling clock edge.
module tb_uart_receiver;

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
    localparam logic [7:0] SPIKE_EXP = 8'h96;
`else
    localparam int MAJ = 0;
    localparam logic [7:0] SPIKE_EXP = 8'h69;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ctrl_init = 1'b0;
    logic [7:0] ctrl_baud_divisor = 8'd16;
    logic       ctrl_stop_bits = 1'b0;
    logic       ctrl_parity_ena = 1'b0;
    logic       ctrl_parity_type = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       rx_overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_ovr = 0;
    int k_start;

    logic [7:0] q_data[$];
    logic       q_perr[$];
    logic       q_ferr[$];
    int         q_cyc[$];

    uart_receiver #(.BDWIDTH(8)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ctrl_init         (ctrl_init),
        .ctrl_baud_divisor (ctrl_baud_divisor),
        .ctrl_stop_bits    (ctrl_stop_bits),
        .ctrl_parity_ena   (ctrl_parity_ena),
        .ctrl_parity_type  (ctrl_parity_type),
        .uart_rxd          (uart_rxd),
        .rx_data           (rx_data),
        .rx_perr           (rx_perr),
        .rx_ferr           (rx_ferr),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .rx_overrun        (rx_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            q_data.push_back(rx_data);
            q_perr.push_back(rx_perr);
            q_ferr.push_back(rx_ferr);
            q_cyc.push_back(cyc);
        end
        if (rx_overrun) n_ovr++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Holds one bit for D cycles; with spike, inverts it for the single cycle seen at mid-bit.
    task automatic bit_time(input logic b, input logic spike);
        int d;
        d = int'(ctrl_baud_divisor);
        uart_rxd = b;
        if (spike) begin
            repeat (d / 2) @(posedge clk);
            #1 uart_rxd = ~b;
            @(posedge clk);
            #1 uart_rxd = b;
            repeat (d - d / 2 - 1) @(posedge clk);
            #1;
        end else begin
            repeat (d) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop0,
                              input logic spike, output int k);
        k = cyc;
        bit_time(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) bit_time(data[i], spike);
        if (ctrl_parity_ena) bit_time((^data) ^ ctrl_parity_type ^ par_flip, 1'b0);
        bit_time(~stop0, 1'b0);
        if (ctrl_stop_bits) bit_time(~stop0, 1'b0);
    endtask

    task automatic wait_words(input int n, input int budget);
        int t;
        t = 0;
        while (q_data.size() < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (q_data.size() < n) check_val("timeout", q_data.size(), n);
    endtask

    task automatic expect_word(input string tag, input int idx, input logic [7:0] d,
                               input logic pe, input logic fe);
        if (idx >= q_data.size()) begin
            check_val({tag, "_present"}, q_data.size(), idx + 1);
            return;
        end
        check_val({tag, "_data"}, q_data[idx], d);
        check_val({tag, "_perr"}, q_perr[idx], pe);
        check_val({tag, "_ferr"}, q_ferr[idx], fe);
    endtask

    task automatic expect_latency(input string tag, input int idx, input int k, input int lat);
        if (idx >= q_cyc.size()) begin
            check_val({tag, "_present"}, q_cyc.size(), idx + 1);
            return;
        end
        check_val(tag, q_cyc[idx] - k - 1, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_data", rx_data, 0);
        check_val("rst_valid", rx_valid, 0);
        check_val("rst_perr", rx_perr, 0);
        check_val("rst_ferr", rx_ferr, 0);
        check_val("rst_overrun", rx_overrun, 0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

        // 8N1, D=16
        align();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, k_start);
        wait_words(1, 300);
        expect_word("t1", 0, 8'hA5, 1'b0, 1'b0);
        expect_latency("t1_latency", 0, k_start, 155 + MAJ);

        // 8E2 back-to-back, good then inverted parity
        ctrl_stop_bits = 1'b1;
        ctrl_parity_ena = 1'b1;
        ctrl_parity_type = 1'b0;
        align();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, k_start);
        send_frame(8'h3D, 1'b0, 1'b0, 1'b0, k_start);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, k_start);
        send_frame(8'h3D, 1'b1, 1'b0, 1'b0, k_start);
        wait_words(5, 400);
        expect_word("t2_3c", 1, 8'h3C, 1'b0, 1'b0);
        expect_word("t2_3d", 2, 8'h3D, 1'b0, 1'b0);
        expect_word("t2_3c_bad", 3, 8'h3C, 1'b1, 1'b0);
        expect_word("t2_3d_bad", 4, 8'h3D, 1'b1, 1'b0);

        // D=10 8N1: framing error, then break, then a clean frame
        ctrl_baud_divisor = 8'd10;
        ctrl_stop_bits = 1'b0;
        ctrl_parity_ena = 1'b0;
        align();
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, k_start);
        repeat (300) @(posedge clk);
        #1;
        check_val("t3_break_cnt", q_data.size(), 6);
        expect_word("t3_ferr", 5, 8'h55, 1'b0, 1'b1);
        uart_rxd = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, k_start);
        wait_words(7, 300);
        repeat (100) @(posedge clk);
        #1;
        check_val("t3_after_break_cnt", q_data.size(), 7);
        expect_word("t3_12", 6, 8'h12, 1'b0, 1'b0);

        // Overrun with downstream stalled
        ctrl_baud_divisor = 8'd16;
        rx_ready = 1'b0;
        align();
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, k_start);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, k_start);
        repeat (20) @(posedge clk);
        #1;
        check_val("t4_overrun_cycles", n_ovr, 1);
        check_val("t4_held_valid", rx_valid, 1);
        check_val("t4_held_data", rx_data, 8'h11);
        check_val("t4_held_cnt", q_data.size(), 7);
        rx_ready = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check_val("t4_deliv_cnt", q_data.size(), 8);
        expect_word("t4_11", 7, 8'h11, 1'b0, 1'b0);
        check_val("t4_valid_clear", rx_valid, 0);

        // Short glitch on idle line
        align();
        uart_rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 uart_rxd = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check_val("t5_glitch_cnt", q_data.size(), 8);

        // Reset mid-DATA with a word held, then a fresh frame
        rx_ready = 1'b0;
        align();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, k_start);
        repeat (5) @(posedge clk);
        #1;
        check_val("t5_pre_valid", rx_valid, 1);
        bit_time(1'b0, 1'b0);
        bit_time(1'b0, 1'b0);
        bit_time(1'b1, 1'b0);
        bit_time(1'b1, 1'b0);
        reset_n = 1'b0;
        #2;
        check_val("t5_rst_valid", rx_valid, 0);
        check_val("t5_rst_data", rx_data, 0);
        check_val("t5_rst_overrun", rx_overrun, 0);
        uart_rxd = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        rx_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, k_start);
        wait_words(9, 300);
        repeat (100) @(posedge clk);
        #1;
        check_val("t5_after_rst_cnt", q_data.size(), 9);
        expect_word("t5_7e", 8, 8'h7E, 1'b0, 1'b0);

        // One-cycle inverted spike at every data sample point
        align();
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, k_start);
        wait_words(10, 300);
        expect_word("t6_spike", 9, SPIKE_EXP, 1'b0, 1'b0);
        expect_latency("t6_latency", 9, k_start, 155 + MAJ);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
